fpu_apb_sequencer: RTL and testbench

//  APB master that sits directly upstream of the FPU APB peripheral and drives its slave port.

---
 rtl/fpu_apb_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_fpu_apb_sequencer.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_apb_sequencer.sv
// fpu_apb_sequencer: APB master that runs the FPU peripheral register
// sequence (write OP1, OP2, OP_SEL; poll STATUS; read RESULT) for one
// command at a time and queues each outcome in a first-word-fall-through
// response FIFO.
module fpu_apb_sequencer #(
   parameter int unsigned               APB_ADDR_WIDTH = 32,
   parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1A10_C000,
   parameter int unsigned               RSP_DEPTH      = 4,
   parameter int unsigned               POLL_LIMIT     = 16
) (
   input  logic                      CLK,
   input  logic                      RST,
   // command port
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [31:0]               cmd_op1,
   input  logic [31:0]               cmd_op2,
   input  logic [2:0]                cmd_opsel,
   // response port
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [31:0]               rsp_data,
   output logic [1:0]                rsp_err,
   output logic                      busy,
   // APB master
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   localparam int unsigned PTR_W  = $clog2(RSP_DEPTH);
   localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);
   localparam int unsigned POLL_W = $clog2(POLL_LIMIT + 1);

   localparam logic [APB_ADDR_WIDTH-1:0] OFF_OP1    = APB_ADDR_WIDTH'(32'h00);
   localparam logic [APB_ADDR_WIDTH-1:0] OFF_OP2    = APB_ADDR_WIDTH'(32'h04);
   localparam logic [APB_ADDR_WIDTH-1:0] OFF_OPSEL  = APB_ADDR_WIDTH'(32'h08);
   localparam logic [APB_ADDR_WIDTH-1:0] OFF_RESULT = APB_ADDR_WIDTH'(32'h0C);
   localparam logic [APB_ADDR_WIDTH-1:0] OFF_STATUS = APB_ADDR_WIDTH'(32'h10);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_OP1, S_WR_OP2, S_WR_SEL, S_POLL, S_RD_RES
   } state_e;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_SLVERR  = 2'b01,
      ERR_TIMEOUT = 2'b10
   } err_e;

   typedef struct packed {
      logic [31:0] data;
      err_e        err;
   } rsp_t;

   // sequencer state
   state_e              state_q, state_d;
   logic                access_q, access_d;   // 0 = SETUP phase, 1 = ACCESS phase
   logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
   logic [31:0]         op1_q, op2_q;
   logic [2:0]          opsel_q;
   logic                load_cmd;

   // response FIFO
   rsp_t                mem_q [RSP_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q;
   logic                push, pop;
   rsp_t                push_entry;
   rsp_t                head;

   // A slot is reserved before accepting, so the eventual push never finds the FIFO full.
   assign cmd_ready = (state_q == S_IDLE) && (count_q < CNT_W'(RSP_DEPTH));
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = (count_q != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign head      = mem_q[rd_ptr_q];
   assign rsp_data  = rsp_valid ? head.data : 32'd0;
   assign rsp_err   = rsp_valid ? head.err  : ERR_OK;

   // Sequencer registers: state, APB phase, poll counter and the captured command.
   // NOTE: an asynchronous reset here makes PSEL/PENABLE fall the moment RST rises, not at the next edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         access_q   <= 1'b0;
         poll_cnt_q <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         opsel_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         access_q   <= access_d;
         poll_cnt_q <= poll_cnt_d;
         if (load_cmd) begin
            op1_q   <= cmd_op1;
            op2_q   <= cmd_op2;
            opsel_q <= cmd_opsel;
         end
      end
   end

   // Next-state logic: one APB transfer per state, advancing on the completing ACCESS.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves a latch behind.
      state_d    = state_q;
      access_d   = access_q;
      poll_cnt_d = poll_cnt_q;
      load_cmd   = 1'b0;
      push       = 1'b0;
      push_entry = '0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_d    = S_WR_OP1;
               access_d   = 1'b0;
               poll_cnt_d = '0;
               load_cmd   = 1'b1;
            end
         end
         default: begin
            if (!access_q) begin
               access_d = 1'b1;
            end else if (PREADY) begin
               // completing ACCESS: the next transfer (if any) starts with a SETUP
               access_d = 1'b0;
               if (PSLVERR) begin
                  push           = 1'b1;
                  push_entry.err = ERR_SLVERR;
                  state_d        = S_IDLE;
               end else begin
                  case (state_q)
                     S_WR_OP1: state_d = S_WR_OP2;
                     S_WR_OP2: state_d = S_WR_SEL;
                     S_WR_SEL: state_d = S_POLL;
                     S_POLL: begin
                        if (PRDATA[0]) begin
                           state_d = S_RD_RES;
                        end else if (poll_cnt_q == POLL_W'(POLL_LIMIT - 1)) begin
                           push           = 1'b1;
                           push_entry.err = ERR_TIMEOUT;
                           state_d        = S_IDLE;
                        end else begin
                           poll_cnt_d = poll_cnt_q + 1'b1;
                        end
                     end
                     S_RD_RES: begin
                        push            = 1'b1;
                        push_entry.data = PRDATA;
                        push_entry.err  = ERR_OK;
                        state_d         = S_IDLE;
                     end
                     default: state_d = S_IDLE;
                  endcase
               end
            end
         end
      endcase
   end

   // APB drive: address, data and direction decoded from the state, so they hold through wait states.
   always_comb begin
      PSEL    = (state_q != S_IDLE);
      PENABLE = access_q;
      PWRITE  = 1'b0;
      PADDR   = '0;
      PWDATA  = '0;
      case (state_q)
         S_WR_OP1: begin
            PWRITE = 1'b1;
            PADDR  = BASE_ADDR + OFF_OP1;
            PWDATA = op1_q;
         end
         S_WR_OP2: begin
            PWRITE = 1'b1;
            PADDR  = BASE_ADDR + OFF_OP2;
            PWDATA = op2_q;
         end
         S_WR_SEL: begin
            PWRITE = 1'b1;
            PADDR  = BASE_ADDR + OFF_OPSEL;
            PWDATA = {29'd0, opsel_q};
         end
         S_POLL:   PADDR = BASE_ADDR + OFF_STATUS;
         S_RD_RES: PADDR = BASE_ADDR + OFF_RESULT;
         default: ;
      endcase
   end

   // FIFO pointers and occupancy; pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

   // FIFO storage write.
   // NOTE: storage is not reset; occupancy is, and rsp_data is masked while the FIFO is empty.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

endmodule

// File: tb/tb_fpu_apb_sequencer.sv
// tb_fpu_apb_sequencer: drives commands into fpu_apb_sequencer, emulates the
// FPU APB peripheral, and checks APB traffic, latency and responses against
// a transaction-level model of the command sequence.
module tb_fpu_apb_sequencer;

   localparam logic [31:0] BASE    = 32'h1A10_C000;
   localparam int          P_LIMIT = 16;
   localparam int          DEPTH   = 4;
   localparam logic [31:0] A_OP1   = BASE + 32'h00;
   localparam logic [31:0] A_OP2   = BASE + 32'h04;
   localparam logic [31:0] A_SEL   = BASE + 32'h08;
   localparam logic [31:0] A_RES   = BASE + 32'h0C;
   localparam logic [31:0] A_STAT  = BASE + 32'h10;

   logic        CLK, RST;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_op1, cmd_op2;
   logic [2:0]  cmd_opsel;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_err;
   logic        busy;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

   typedef struct {
      logic [31:0] addr;
      bit          wr;
      logic [31:0] data;
   } xfer_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  err;
   } rsp_t;

   xfer_t       log_q[$];    // transfers seen by the peripheral model
   xfer_t       exp_x[$];    // transfers expected for the current command
   rsp_t        exp_q[$];    // responses expected out of the FIFO, in order
   int          wait_q[$];   // wait states per transfer of the current command
   int          err_idx;     // transfer index that gets PSLVERR (-1: none)
   int          ready_after; // STATUS reads returning 0 before bit0 goes 1
   logic [31:0] result_val;
   int          xfer_idx, status_reads;
   int          n_cmp, n_mis;
   bit          pop_rand;

   fpu_apb_sequencer #(
      .APB_ADDR_WIDTH (32),
      .BASE_ADDR      (BASE),
      .RSP_DEPTH      (DEPTH),
      .POLL_LIMIT     (P_LIMIT)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op1   (cmd_op1),
      .cmd_op2   (cmd_op2),
      .cmd_opsel (cmd_opsel),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PWRITE    (PWRITE),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   // Peripheral model: answers on the negative edge, checks signal stability across ACCESS.
   initial begin
      bit          in_access;
      int          wait_left;
      logic [31:0] s_addr, s_wdata, r;
      bit          s_wr;
      in_access = 0;
      wait_left = 0;
      PREADY    = 1'b1;
      PSLVERR   = 1'b0;
      PRDATA    = '0;
      forever begin
         @(negedge CLK);
         PREADY  = 1'b1;
         PSLVERR = 1'b0;
         PRDATA  = $urandom;
         if (RST) begin
            in_access = 0;
            wait_q.delete();
         end else if (PSEL && !PENABLE) begin
            s_addr    = PADDR;
            s_wdata   = PWDATA;
            s_wr      = PWRITE;
            in_access = 0;
         end else if (PSEL && PENABLE) begin
            if (!in_access) begin
               in_access = 1;
               wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            end
            n_cmp++;
            if (PADDR !== s_addr || PWRITE !== s_wr || PWDATA !== s_wdata) begin
               n_mis++;
               $display("FAIL apb_stable: access addr=%h wr=%b wdata=%h, required setup addr=%h wr=%b wdata=%h",
                        PADDR, PWRITE, PWDATA, s_addr, s_wr, s_wdata);
            end
            if (wait_left > 0) begin
               PREADY = 1'b0;
               wait_left--;
            end else begin
               if (xfer_idx == err_idx) PSLVERR = 1'b1;
               if (!PWRITE && PADDR == A_STAT) begin
                  r = $urandom;
                  PRDATA = {r[31:1], (status_reads >= ready_after)};
                  status_reads++;
               end else if (!PWRITE && PADDR == A_RES) begin
                  PRDATA = result_val;
               end
               log_q.push_back('{PADDR, PWRITE, PWDATA});
               xfer_idx++;
               in_access = 0;
            end
         end
      end
   end

   // One clock step; pops are checked against the expected-response queue just before the edge.
   task automatic tick();
      rsp_t e;
      if (pop_rand) rsp_ready = ($urandom_range(0, 1) == 1);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_mis++;
            $display("FAIL pop_unexpected: got data=%h err=%b, required no response", rsp_data, rsp_err);
         end else begin
            e = exp_q.pop_front();
            if (rsp_data !== e.data || rsp_err !== e.err) begin
               n_mis++;
               $display("FAIL pop_order: got data=%h err=%b, required data=%h err=%b",
                        rsp_data, rsp_err, e.data, e.err);
            end
         end
      end
      @(posedge CLK);
      #1;
   endtask

   // Transaction-level model of one command under the current peripheral settings.
   task automatic model_cmd(input logic [31:0] op1, input logic [31:0] op2,
                            input logic [2:0] opsel, output int lat);
      rsp_t        r;
      logic [31:0] wa[3];
      logic [31:0] wd[3];
      bit          done, ready;
      int          idx;
      wa[0] = A_OP1; wd[0] = op1;
      wa[1] = A_OP2; wd[1] = op2;
      wa[2] = A_SEL; wd[2] = {29'd0, opsel};
      exp_x.delete();
      r.data = '0;
      r.err  = 2'b00;
      done   = 0;
      ready  = 0;
      idx    = 0;
      for (int i = 0; i < 3; i++) begin
         if (!done) begin
            exp_x.push_back('{wa[i], 1'b1, wd[i]});
            if (err_idx == idx) begin r.err = 2'b01; done = 1; end
            idx++;
         end
      end
      for (int p = 0; p < P_LIMIT; p++) begin
         if (!done && !ready) begin
            exp_x.push_back('{A_STAT, 1'b0, 32'd0});
            if (err_idx == idx) begin r.err = 2'b01; done = 1; end
            else if (p >= ready_after) ready = 1;
            idx++;
         end
      end
      if (!done && !ready) begin r.err = 2'b10; done = 1; end
      if (!done) begin
         exp_x.push_back('{A_RES, 1'b0, 32'd0});
         if (err_idx == idx) r.err = 2'b01;
         else r.data = result_val;
      end
      exp_q.push_back(r);
      lat = 1;
      for (int i = 0; i < exp_x.size(); i++)
         lat += 2 + ((i < wait_q.size()) ? wait_q[i] : 0);
   endtask

   task automatic prep_slave();
      xfer_idx     = 0;
      status_reads = 0;
      log_q.delete();
   endtask

   task automatic issue(input logic [31:0] op1, input logic [31:0] op2,
                        input logic [2:0] opsel, output bit ok);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op1   = op1;
      cmd_op2   = op2;
      cmd_opsel = opsel;
      while (cmd_ready !== 1'b1 && n < 300) begin tick(); n++; end
      ok = (cmd_ready === 1'b1);
      if (ok) tick();
      cmd_valid = 1'b0;
      cmd_op1   = $urandom;
      cmd_op2   = $urandom;
      cmd_opsel = 3'($urandom);
   endtask

   // Wait for busy to drop, then check latency and the full APB transfer list.
   task automatic finish_cmd(input int lat, input string name);
      int c = 1;
      while (busy === 1'b1 && c < 800) begin tick(); c++; end
      n_cmp++;
      if (c != lat) begin
         n_mis++;
         $display("FAIL %s_latency: busy low in cycle %0d, required cycle %0d", name, c, lat);
      end
      n_cmp++;
      if (log_q.size() != exp_x.size()) begin
         n_mis++;
         $display("FAIL %s_xfer_count: got %0d transfers, required %0d", name, log_q.size(), exp_x.size());
      end else begin
         for (int i = 0; i < exp_x.size(); i++) begin
            n_cmp++;
            if (log_q[i].addr !== exp_x[i].addr || log_q[i].wr !== exp_x[i].wr ||
                (exp_x[i].wr && log_q[i].data !== exp_x[i].data)) begin
               n_mis++;
               $display("FAIL %s_xfer%0d: got addr=%h wr=%b data=%h, required addr=%h wr=%b data=%h",
                        name, i, log_q[i].addr, log_q[i].wr, log_q[i].data,
                        exp_x[i].addr, exp_x[i].wr, exp_x[i].data);
            end
         end
      end
   endtask

   task automatic run_cmd(input logic [31:0] op1, input logic [31:0] op2,
                          input logic [2:0] opsel, input string name);
      int lat;
      bit ok;
      model_cmd(op1, op2, opsel, lat);
      prep_slave();
      issue(op1, op2, opsel, ok);
      if (!ok) begin
         n_cmp++;
         n_mis++;
         $display("FAIL %s_accept: cmd_ready=%b after 300 cycles, required 1", name, cmd_ready);
         void'(exp_q.pop_back());
      end else begin
         finish_cmd(lat, name);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      pop_rand  = 0;
      rsp_ready = 1'b1;
      while (exp_q.size() > 0 && n < 40) begin tick(); n++; end
      rsp_ready = 1'b0;
      n_cmp++;
      if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
         n_mis++;
         $display("FAIL %s_drain: %0d responses missing, rsp_valid=%b, required 0 missing and rsp_valid=0",
                  name, exp_q.size(), rsp_valid);
      end
   endtask

   task automatic set_plain(input int ra, input logic [31:0] res);
      wait_q.delete();
      err_idx     = -1;
      ready_after = ra;
      result_val  = res;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      n_cmp++;
      if ({PSEL, PENABLE, PWRITE, busy, rsp_valid} !== 5'b0 || PADDR !== 32'd0 || PWDATA !== 32'd0) begin
         n_mis++;
         $display("FAIL reset_outputs: psel=%b pen=%b pwr=%b busy=%b rsp_valid=%b paddr=%h pwdata=%h, required all 0",
                  PSEL, PENABLE, PWRITE, busy, rsp_valid, PADDR, PWDATA);
      end
      RST = 1'b0;
      tick();
      n_cmp++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
         n_mis++;
         $display("FAIL reset_release: cmd_ready=%b busy=%b rsp_valid=%b, required 1 0 0", cmd_ready, busy, rsp_valid);
      end
   endtask

   task automatic test_basic();
      pop_rand  = 0;
      rsp_ready = 1'b0;
      set_plain(0, 32'h4040_0000);
      run_cmd(32'h3F80_0000, 32'h4000_0000, 3'd0, "basic");
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h4040_0000 || rsp_err !== 2'b00) begin
         n_mis++;
         $display("FAIL basic_rsp: valid=%b data=%h err=%b, required 1 40400000 00", rsp_valid, rsp_data, rsp_err);
      end
      drain("basic");
   endtask

   task automatic test_wait_states();
      set_plain(0, $urandom);
      wait_q.push_back(0);
      wait_q.push_back(2);
      run_cmd($urandom, $urandom, 3'd3, "wait_op2");
      drain("wait_op2");
      set_plain(2, $urandom);
      for (int i = 0; i < 8; i++) wait_q.push_back(int'($urandom_range(1, 3)));
      run_cmd($urandom, $urandom, 3'd6, "wait_all");
      drain("wait_all");
   endtask

   task automatic test_timeout();
      set_plain(1000, $urandom);
      run_cmd($urandom, $urandom, 3'd1, "timeout");
      drain("timeout");
      set_plain(P_LIMIT - 1, $urandom);
      run_cmd($urandom, $urandom, 3'd2, "last_poll");
      drain("last_poll");
   endtask

   task automatic test_slverr();
      set_plain(0, $urandom);
      err_idx = 2;
      run_cmd($urandom, $urandom, 3'd4, "slverr_sel");
      n_cmp++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_err !== 2'b01) begin
         n_mis++;
         $display("FAIL slverr_sel_state: busy=%b cmd_ready=%b valid=%b data=%h err=%b, required 0 1 1 0 01",
                  busy, cmd_ready, rsp_valid, rsp_data, rsp_err);
      end
      drain("slverr_sel");
      set_plain(0, $urandom);
      err_idx = 4;
      run_cmd($urandom, $urandom, 3'd7, "slverr_res");
      drain("slverr_res");
   endtask

   task automatic test_fifo_full();
      int          lat, seen;
      logic [31:0] a, b;
      pop_rand  = 0;
      rsp_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         set_plain(int'($urandom_range(0, 2)), $urandom);
         run_cmd($urandom, $urandom, 3'($urandom), "fifo_fill");
      end
      set_plain(0, $urandom);
      a = $urandom;
      b = $urandom;
      model_cmd(a, b, 3'd5, lat);
      prep_slave();
      cmd_valid = 1'b1;
      cmd_op1   = a;
      cmd_op2   = b;
      cmd_opsel = 3'd5;
      seen = 0;
      repeat (30) begin
         tick();
         if (cmd_ready !== 1'b0 || busy !== 1'b0) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_mis++;
         $display("FAIL fifo_full_block: %0d cycles with cmd_ready or busy high, required 0", seen);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_mis++;
         $display("FAIL fifo_slot_freed: cmd_ready=%b after one pop, required 1", cmd_ready);
      end
      tick();
      cmd_valid = 1'b0;
      cmd_op1   = $urandom;
      cmd_op2   = $urandom;
      finish_cmd(lat, "fifo_fifth");
      drain("fifo_full");
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      pop_rand  = 0;
      rsp_ready = 1'b0;
      set_plain(0, $urandom);
      run_cmd($urandom, $urandom, 3'd1, "pre_reset");
      set_plain(1000, $urandom);
      prep_slave();
      issue($urandom, $urandom, 3'd2, ok);
      n = 0;
      while (!(PSEL === 1'b1 && PENABLE === 1'b1 && PADDR === A_STAT) && n < 100) begin tick(); n++; end
      n_cmp++;
      if (!ok || n >= 100) begin
         n_mis++;
         $display("FAIL reset_mid_reach: accepted=%b waited %0d cycles, required accept and a STATUS access", ok, n);
      end
      #2;
      RST = 1'b1;
      #1;
      n_cmp++;
      if ({PSEL, PENABLE, rsp_valid, busy} !== 4'b0) begin
         n_mis++;
         $display("FAIL reset_mid_async: psel=%b pen=%b rsp_valid=%b busy=%b, required all 0",
                  PSEL, PENABLE, rsp_valid, busy);
      end
      exp_q.delete();
      tick();
      RST = 1'b0;
      n_cmp++;
      if ({PSEL, PENABLE, rsp_valid, busy} !== 4'b0 || cmd_ready !== 1'b1) begin
         n_mis++;
         $display("FAIL reset_mid_idle: psel=%b pen=%b rsp_valid=%b busy=%b cmd_ready=%b, required 0 0 0 0 1",
                  PSEL, PENABLE, rsp_valid, busy, cmd_ready);
      end
      set_plain(1, $urandom);
      run_cmd($urandom, $urandom, 3'd3, "post_reset");
      drain("post_reset");
   endtask

   task automatic test_random();
      int choices[7] = '{0, 1, 2, 3, 15, 16, 40};
      pop_rand = 1;
      for (int k = 0; k < 25; k++) begin
         wait_q.delete();
         for (int i = 0; i < 24; i++)
            wait_q.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
         ready_after = choices[$urandom_range(0, 6)];
         err_idx     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1;
         result_val  = $urandom;
         run_cmd($urandom, $urandom, 3'($urandom), "random");
      end
      drain("random");
      set_plain(0, '0);
   endtask

   initial begin
      n_cmp       = 0;
      n_mis       = 0;
      pop_rand    = 0;
      err_idx     = -1;
      ready_after = 0;
      result_val  = '0;
      xfer_idx    = 0;
      status_reads = 0;
      cmd_valid   = 1'b0;
      cmd_op1     = '0;
      cmd_op2     = '0;
      cmd_opsel   = '0;
      rsp_ready   = 1'b0;
      test_reset();
      test_basic();
      test_wait_states();
      test_timeout();
      test_slverr();
      test_fifo_full();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
